// File: rtl/led7_scan_decoder.sv
// Multiplexed 7-segment scan decoder: recovers a 4-digit hex value from
// active-low segment lines and a one-hot digit strobe, capturing each slot once it is stable.
module led7_scan_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        E,
    input  logic        F,
    input  logic        G,
    input  logic [3:0]  DigitEn,
    output logic [15:0] Value,
    output logic        Valid,
    output logic        Err,
    output logic [1:0]  ErrDigit
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    localparam logic [6:0] SegOff = 7'h7F;

    logic [6:0]  seg_q, seg_prev_q;
    logic [3:0]  en_q, en_prev_q;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_digit_q, err_digit_d;

    logic        one_hot;
    logic        changed;
    logic        capture;
    logic [1:0]  slot;
    logic        legal;
    logic [3:0]  nibble;

    assign one_hot = (en_q != 4'd0) && ((en_q & (en_q - 4'd1)) == 4'd0);
    assign changed = {seg_q, en_q} != {seg_prev_q, en_prev_q};

    always_comb begin
        slot = 2'd0;
        unique case (en_q)
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: slot = 2'd0;
        endcase
    end

    // Segment order is A..G from MSB to LSB, active-low.
    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (seg_q)
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b0001000: nibble = 4'hA;
            7'b1100000: nibble = 4'hB;
            7'b0110001: nibble = 4'hC;
            7'b1000010: nibble = 4'hD;
            7'b0110000: nibble = 4'hE;
            7'b0111000: nibble = 4'hF;
            default:    legal  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (one_hot) begin
                    state_d = StSettle;
                    cnt_d   = 4'd1;
                end
            end
            StSettle: begin
                if (!changed) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'(STABLE_CNT)) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end
                end else if (one_hot) begin
                    cnt_d = 4'd1;
                end else begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            end
            StHold: begin
                if (changed) begin
                    state_d = one_hot ? StSettle : StIdle;
                    cnt_d   = one_hot ? 4'd1 : 4'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A capture can never land on the frame-publish edge: the slot that completed
    // the mask is still in HOLD one edge later.
    always_comb begin
        mask_d      = mask_q;
        shadow_d    = shadow_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;
        if (mask_q == 4'hF) begin
            value_d = shadow_q;
            valid_d = 1'b1;
            mask_d  = 4'h0;
        end
        if (capture) begin
            if (legal) begin
                shadow_d[{slot, 2'b00} +: 4] = nibble;
                mask_d[slot]                 = 1'b1;
            end else begin
                err_d       = 1'b1;
                err_digit_d = slot;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            seg_q       <= SegOff;
            en_q        <= 4'd0;
            seg_prev_q  <= SegOff;
            en_prev_q   <= 4'd0;
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            mask_q      <= 4'd0;
            shadow_q    <= 16'h0000;
            value_q     <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 2'd0;
        end else begin
            seg_q       <= {A, B, C, D, E, F, G};
            en_q        <= DigitEn;
            seg_prev_q  <= seg_q;
            en_prev_q   <= en_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign Value    = value_q;
    assign Valid    = valid_q;
    assign Err      = err_q;
    assign ErrDigit = err_digit_q;

endmodule

// File: tb/tb_led7_scan_decoder.sv
// Bench for led7_scan_decoder: directed scenarios plus random scans, checked every cycle
// against a run-length reference model of the capture rules.
module tb_led7_scan_decoder;

    localparam int S = 4;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [6:0]  seg_in;
    logic [3:0]  en_in;
    logic [15:0] Value;
    logic        Valid;
    logic        Err;
    logic [1:0]  ErrDigit;

    led7_scan_decoder #(.STABLE_CNT(S)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .A       (seg_in[6]),
        .B       (seg_in[5]),
        .C       (seg_in[4]),
        .D       (seg_in[3]),
        .E       (seg_in[2]),
        .F       (seg_in[1]),
        .G       (seg_in[0]),
        .DigitEn (en_in),
        .Value   (Value),
        .Valid   (Valid),
        .Err     (Err),
        .ErrDigit(ErrDigit)
    );

    always #5 Clock = ~Clock;

    logic [6:0]  glyph [16];

    // Model: a capture happens when the registered sample has been identical for
    // exactly S consecutive edges and its strobe is one-hot.
    logic [10:0] m_reg;
    int          m_run;
    logic [3:0]  m_mask;
    logic [15:0] m_shadow, m_value;
    logic        m_valid, m_err;
    logic [1:0]  m_errdig;

    int passes = 0, checks = 0, fails = 0;
    int valid_seen = 0, err_seen = 0;

    function automatic int find_glyph(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
        return -1;
    endfunction

    function automatic int slot_of(input logic [3:0] e);
        for (int k = 0; k < 4; k++) if (e == 4'(1 << k)) return k;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [10:0] sample);
        int k, g;
        logic [10:0] loaded;
        if (!rst) begin
            m_mask = 0; m_shadow = 0; m_value = 0;
            m_valid = 0; m_err = 0; m_errdig = 0;
            loaded = {7'h7F, 4'h0};
        end else begin
            m_valid = (m_mask == 4'hF);
            if (m_valid) begin
                m_value = m_shadow;
                m_mask  = 0;
            end
            m_err = 0;
            k = slot_of(m_reg[3:0]);
            if (m_run == S && k >= 0) begin
                g = find_glyph(m_reg[10:4]);
                if (g >= 0) begin
                    m_shadow[4*k +: 4] = 4'(g);
                    m_mask[k] = 1'b1;
                end else begin
                    m_err = 1;
                    m_errdig = 2'(k);
                end
            end
            loaded = sample;
        end
        if (loaded == m_reg) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else begin
            m_reg = loaded;
            m_run = 1;
        end
    endtask

    task automatic step(input logic rst, input logic [6:0] seg, input logic [3:0] en);
        Resetn = rst;
        seg_in = seg;
        en_in  = en;
        @(posedge Clock);
        model_edge(rst, {seg, en});
        #1;
        if (Valid === 1'b1) valid_seen++;
        if (Err === 1'b1) err_seen++;
        check("valid", 32'(Valid), 32'(m_valid));
        check("err", 32'(Err), 32'(m_err));
        check("errdigit", 32'(ErrDigit), 32'(m_errdig));
        check("value", 32'(Value), 32'(m_value));
    endtask

    task automatic hold(input logic [6:0] seg, input logic [3:0] en, input int n);
        for (int i = 0; i < n; i++) step(1'b1, seg, en);
    endtask

    initial begin
        int r, n;
        logic [6:0] s;
        logic [3:0] e;
        logic rst;
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010;
        glyph[3]  = 7'b0000110; glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000;
        glyph[15] = 7'b0111000;
        m_reg = {7'h7F, 4'h0};
        m_run = 0;

        // Reset: all outputs must read zero.
        for (int i = 0; i < 3; i++) step(1'b0, glyph[8], 4'b0001);
        check("rst_value", 32'(Value), 32'h0);

        // Full scan of 1,2,3,4.
        valid_seen = 0; err_seen = 0;
        hold(glyph[1], 4'b0001, 8);
        hold(glyph[2], 4'b0010, 8);
        hold(glyph[3], 4'b0100, 8);
        hold(glyph[4], 4'b1000, 8);
        hold(7'h7F, 4'b0000, 2);
        check("scan_valid_cnt", valid_seen, 1);
        check("scan_value", 32'(Value), 32'h4321);
        check("scan_err_cnt", err_seen, 0);

        // Slot 2 held too briefly: frame only completes after a stable slot 2.
        valid_seen = 0;
        hold(glyph[5], 4'b0001, 8);
        hold(glyph[6], 4'b0010, 8);
        hold(glyph[7], 4'b1000, 8);
        hold(glyph[9], 4'b0100, 3);
        hold(glyph[5], 4'b0001, 8);
        check("short_no_valid", valid_seen, 0);
        hold(glyph[9], 4'b0100, 8);
        hold(7'h7F, 4'b0000, 2);
        check("short_valid_cnt", valid_seen, 1);
        check("short_value", 32'(Value), 32'h7965);

        // All-off glyph on slot 1.
        err_seen = 0;
        hold(7'h7F, 4'b0010, 6);
        hold(7'h7F, 4'b0000, 2);
        check("blank_err_cnt", err_seen, 1);
        check("blank_errdigit", 32'(ErrDigit), 32'd1);

        // Multi-hot strobe never captures.
        valid_seen = 0; err_seen = 0;
        hold(glyph[3], 4'b0110, 20);
        check("multihot_valid", valid_seen, 0);
        check("multihot_err", err_seen, 0);

        // Flicker between 8 and 0, then steady 8.
        for (int i = 0; i < 3; i++) begin
            hold(glyph[8], 4'b0001, 2);
            hold(glyph[0], 4'b0001, 2);
        end
        hold(glyph[8], 4'b0001, 6);

        // Reset mid-frame, then scan A b C d.
        hold(glyph[1], 4'b0001, 6);
        hold(glyph[1], 4'b0010, 6);
        hold(glyph[1], 4'b0100, 6);
        step(1'b0, glyph[1], 4'b0100);
        step(1'b0, glyph[1], 4'b0100);
        valid_seen = 0; err_seen = 0;
        hold(glyph[10], 4'b0001, 8);
        hold(glyph[11], 4'b0010, 8);
        hold(glyph[12], 4'b0100, 8);
        hold(glyph[13], 4'b1000, 8);
        hold(7'h7F, 4'b0000, 2);
        check("rst_scan_valid_cnt", valid_seen, 1);
        check("rst_scan_value", 32'(Value), 32'hDCBA);
        check("rst_scan_err", err_seen, 0);

        // Random frames with random glyphs.
        for (int f = 0; f < 8; f++)
            for (int k = 0; k < 4; k++)
                hold(glyph[$urandom_range(0, 15)], 4'(1 << k), $urandom_range(5, 7));

        // Random soup: glyphs, junk patterns, odd strobes, rare resets.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) s = glyph[$urandom_range(0, 15)];
            else if (r < 9) s = 7'($urandom);
            else s = 7'h7F;
            r = $urandom_range(0, 9);
            if (r < 7) e = 4'(1 << $urandom_range(0, 3));
            else e = 4'($urandom);
            rst = ($urandom_range(0, 39) != 0);
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) step(rst, s, e);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/led7_scan_decoder.md
LED7_SCAN_DECODER -- requirements
Module: led7_scan_decoder

Interface
REQ-001 The module SHALL have parameter STABLE_CNT, default 4, giving the consecutive identical samples required before a capture (legal range 2..15).
REQ-002 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  reset, synchronous and active-low.
REQ-004 A, B, C, D, E, F, G  input  1 each  segment lines; active-low (0 = segment lit).
REQ-005 DigitEn  input  4  digit strobe, active-high; bit k selects digit slot k (k=0 least significant).
REQ-006 Value  output  16  recovered hex value; slot k occupies bits [4k+3:4k].
REQ-007 Valid  output  1  one-cycle pulse; Value has just been updated with a complete frame.
REQ-008 Err  output  1  one-cycle pulse; a stable pattern was not a legal hex glyph.
REQ-009 ErrDigit  output  2  index of the slot that raised the last Err.

Function
REQ-010 Legal glyphs, with segments listed in the order A B C D E F G: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-011 The module SHALL register {A..G, DigitEn} once per cycle, and all decisions SHALL use the registered copy.
REQ-012 The state machine SHALL have three states:
- IDLE: DigitEn is not one-hot.
- SETTLE: counting stable samples.
- HOLD: the current strobe has already been captured.
REQ-013 From IDLE, a one-hot registered DigitEn SHALL move the machine to SETTLE with the 4-bit stability counter = 1.
REQ-014 In SETTLE, a registered sample identical to the previous one SHALL increment the counter.
REQ-015 In SETTLE, any change in segments or DigitEn SHALL restart the counter at 1 if DigitEn is still one-hot, and SHALL go to IDLE otherwise.
REQ-016 When the counter reaches STABLE_CNT, the module SHALL, on that same edge, decode the pattern and enter HOLD.
REQ-017 On a legal decode, the module SHALL write the nibble into a shadow slot k and set captured-mask bit k.
REQ-018 On an illegal decode, including all-off 1111111, the module SHALL pulse Err, load ErrDigit=k, and leave the shadow slot and mask unchanged.
REQ-019 In HOLD, the module SHALL perform no further capture and SHALL leave HOLD only when the registered sample changes, going to SETTLE (counter=1) or IDLE by the same rule as REQ-015.
REQ-020 When the captured mask becomes 4'b1111, the module SHALL, on the next edge, copy the shadow register to Value, pulse Valid for exactly one cycle, and clear the mask.
REQ-021 Value SHALL hold its last frame between Valid pulses.
REQ-022 Recapturing an already-captured slot before the frame completes SHALL overwrite that shadow nibble, SHALL NOT generate Valid, and SHALL NOT be an error.
REQ-023 A DigitEn value with zero bits or more than one bit set SHALL never cause a capture.
REQ-024 Valid and Err SHALL never assert in the same cycle; a capture completing the mask SHALL be legal by construction.
REQ-025 Latency from the first edge at which the inputs are held steady to the mask update SHALL be STABLE_CNT+1 cycles (1 input register + STABLE_CNT counts).
REQ-026 Outputs SHALL be driven from registers only, with no combinational path from inputs to outputs.

Reset
REQ-027 While Resetn=0 at a rising edge, the module SHALL set state=IDLE, counter=0, mask=0, shadow=0, Value=16'h0000, Valid=0, Err=0, ErrDigit=0 and the input register to all-ones segments with DigitEn=0.
REQ-028 Reset asserted mid-SETTLE or mid-frame SHALL discard the partial frame, with no Valid or Err in the cycle following deassertion.

Verification
REQ-029 Scan digits 0..3 with glyphs 1, 2, 3, 4, each held 8 cycles (STABLE_CNT=4) -> single Valid pulse, Value=16'h4321, Err never asserted.
REQ-030 Digit 2 held only 3 cycles, then DigitEn changes -> no capture for slot 2; no Valid until a later stable capture of slot 2.
REQ-031 Digit 1 shows 1111111 for 6 cycles -> exactly one Err pulse, ErrDigit=1, mask bit 1 stays 0.
REQ-032 DigitEn=4'b0110 held 20 cycles with a legal glyph -> no Valid, no Err, state stays IDLE.
REQ-033 Resetn pulsed low after slots 0..2 are captured, then a full scan of glyphs A, b, C, d -> first Valid after reset carries Value=16'hDCBA.
REQ-034 Glyph flicker between 8 and 0 every 2 cycles on slot 0 -> no capture; then held steady at 8 -> capture after 5 cycles, nibble=8.
